// File: rtl/cpu_io_pkg.sv
// Shared constants for the cpu_io memory-side block: I/O page decode,
// register addresses, STATUS bit positions and the UART TX state encoding.
package cpu_io_pkg;

   localparam logic [3:0]  IoPage     = 4'hF;
   localparam logic [11:0] AddrTxData = 12'h000;
   localparam logic [11:0] AddrStatus = 12'h001;
   localparam logic [11:0] AddrTimer  = 12'h002;

   localparam int unsigned StatusTxFull   = 0;
   localparam int unsigned StatusTxIdle   = 1;
   localparam int unsigned StatusOverflow = 2;

   typedef enum logic [1:0] {
      TxIdle,
      TxStart,
      TxData,
      TxStop
   } tx_state_e;

   // True when a word address falls in the I/O page.
   function automatic logic is_io(input logic [15:0] addr);
      return addr[15:12] == IoPage;
   endfunction

endpackage

// File: rtl/cpu_io_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Pulls bytes through a valid/ready pop interface; when a byte is waiting on
// the last stop cycle it goes straight to the next start bit.
module uart_tx
   import cpu_io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid_i,
   input  logic [7:0] in_data_i,
   output logic       in_ready_o,
   output logic       idle_o,
   output logic       tx_o
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   tx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            last;

   assign last   = (cnt_q == CntMax);
   assign idle_o = (state_q == TxIdle);
   assign tx_o   = tx_q;

   // Next-state, baud/bit counters and registered line value.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      in_ready_o = 1'b0;
      unique case (state_q)
         TxIdle: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               state_d = TxStart;
               shift_d = in_data_i;
               cnt_d   = '0;
               tx_d    = 1'b0;
            end
         end
         TxStart: begin
            if (last) begin
               state_d = TxData;
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TxData: begin
            if (last) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = TxStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (last) begin
               // Accept the next byte here so frames run back to back.
               in_ready_o = 1'b1;
               cnt_d      = '0;
               if (in_valid_i) begin
                  state_d = TxStart;
                  shift_d = in_data_i;
                  tx_d    = 1'b0;
               end else begin
                  state_d = TxIdle;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = TxIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State register with synchronous reset; line idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TxIdle;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/cpu_io.sv
// Memory-side companion to the CPU: passes RAM traffic through, decodes the
// I/O page (0xF000-0xFFFF) holding a FIFO-buffered UART TX, status/overflow
// flags and, when CPU_IO_TIMER_EN is defined, a free-running 16-bit timer.
module cpu_io
   import cpu_io_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_raddr_i,
   input  logic [15:0] cpu_waddr_i,
   input  logic [15:0] cpu_wdata_i,
   input  logic        cpu_wr_i,
   output logic [15:0] cpu_rdata_o,
   input  logic [15:0] ram_rdata_i,
   output logic        ram_wr_o,
   output logic        uart_tx_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   logic [PtrW:0] wptr_q, wptr_d;
   logic [PtrW:0] rptr_q, rptr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic          overflow_q, overflow_d;
   logic          io_sel_q, io_sel_d;
   logic [15:0]   io_rdata_q, io_rdata_d;

   logic          wr_io, wr_txdata, wr_status;
   logic          empty, full, push, pop, reject;
   logic          tx_ready, tx_sh_idle;
   logic [15:0]   status;

   assign wr_io     = cpu_wr_i & is_io(cpu_waddr_i);
   assign ram_wr_o  = cpu_wr_i & ~is_io(cpu_waddr_i);
   assign wr_txdata = wr_io & (cpu_waddr_i[11:0] == AddrTxData);
   assign wr_status = wr_io & (cpu_waddr_i[11:0] == AddrStatus);

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
   assign pop    = tx_ready & ~empty;
   // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
   assign push   = wr_txdata & (~full | pop);
   assign reject = wr_txdata & full & ~pop;

   // STATUS word built from pre-edge state.
   always_comb begin
      status                 = '0;
      status[StatusTxFull]   = full;
      status[StatusTxIdle]   = empty & tx_sh_idle;
      status[StatusOverflow] = overflow_q;
   end

`ifdef CPU_IO_TIMER_EN
   logic        wr_timer;
   logic [15:0] timer_q, timer_d;

   assign wr_timer = wr_io & (cpu_waddr_i[11:0] == AddrTimer);

   // Free-running counter; a CPU load takes priority over the increment.
   always_comb begin
      timer_d = wr_timer ? cpu_wdata_i : timer_q + 16'd1;
   end

   // Timer register.
   always_ff @(posedge clk) begin
      if (reset) timer_q <= 16'h0000;
      else       timer_q <= timer_d;
   end
`else
   logic unused_wdata;
   assign unused_wdata = ^cpu_wdata_i[15:8];
`endif

   // FIFO pointers, storage update, overflow flag and read-path capture.
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      mem_d      = mem_q;
      overflow_d = overflow_q;
      if (push) begin
         mem_d[wptr_q[PtrW-1:0]] = cpu_wdata_i[7:0];
         wptr_d                  = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (wr_status && cpu_wdata_i[StatusOverflow]) overflow_d = 1'b0;
      if (reject) overflow_d = 1'b1;

      io_sel_d   = is_io(cpu_raddr_i);
      io_rdata_d = 16'h0000;
      if (is_io(cpu_raddr_i)) begin
         case (cpu_raddr_i[11:0])
            AddrStatus: io_rdata_d = status;
`ifdef CPU_IO_TIMER_EN
            AddrTimer:  io_rdata_d = timer_q;
`endif
            default:    io_rdata_d = 16'h0000;
         endcase
      end
   end

   // Control state with synchronous reset; resetting pointers discards data.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
         io_sel_q   <= 1'b0;
         io_rdata_q <= 16'h0000;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
         io_sel_q   <= io_sel_d;
         io_rdata_q <= io_rdata_d;
      end
   end

   // FIFO storage; contents are meaningless until pointed at, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign cpu_rdata_o = io_sel_q ? io_rdata_q : ram_rdata_i;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk       (clk),
      .reset     (reset),
      .in_valid_i(~empty),
      .in_data_i (mem_q[rptr_q[PtrW-1:0]]),
      .in_ready_o(tx_ready),
      .idle_o    (tx_sh_idle),
      .tx_o      (uart_tx_o)
   );

endmodule

// File: tb/tb_cpu_io.sv
// Directed bench for cpu_io with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Define CPU_IO_TIMER_EN to exercise the timer.
module tb_cpu_io;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_raddr_i, cpu_waddr_i, cpu_wdata_i;
  logic        cpu_wr_i;
  logic [15:0] cpu_rdata_o;
  logic [15:0] ram_rdata_i;
  logic        ram_wr_o;
  logic        uart_tx_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Simple line receiver
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_frames = 0;
  logic [7:0] rx_shift = 8'h00;
  logic [7:0] rx_bytes [32];

  cpu_io #(
    .FIFO_DEPTH  (Depth),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_raddr_i(cpu_raddr_i),
    .cpu_waddr_i(cpu_waddr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_wr_i   (cpu_wr_i),
    .cpu_rdata_o(cpu_rdata_o),
    .ram_rdata_i(ram_rdata_i),
    .ram_wr_o   (ram_wr_o),
    .uart_tx_o  (uart_tx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode frames from the serial line, counting completed ones.
  always @(negedge clk) begin
    if (reset) begin
      rx_busy <= 1'b0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (uart_tx_o == 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rx_cnt == int'(Cpb) * (1 + i) + 1) rx_shift[i] <= uart_tx_o;
      end
      if (rx_cnt == 10 * int'(Cpb) - 1) begin
        rx_busy                  <= 1'b0;
        rx_bytes[rx_frames % 32] <= rx_shift;
        rx_frames                <= rx_frames + 1;
      end
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] d);
    cpu_waddr_i = a;
    cpu_wdata_i = d;
    cpu_wr_i    = 1'b1;
    step();
    cpu_wr_i    = 1'b0;
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [15:0] exp, input string tag);
    cpu_raddr_i = a;
    step();
    check(tag, cpu_rdata_o, exp);
  endtask

  initial begin
    int         base;
    logic [7:0] byte_v;
    logic       exp_bit;

    reset       = 1'b1;
    cpu_raddr_i = 16'h0010;
    cpu_waddr_i = 16'h0000;
    cpu_wdata_i = 16'h0000;
    cpu_wr_i    = 1'b0;
    ram_rdata_i = 16'hBEEF;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_rdata_ram", cpu_rdata_o, 16'hBEEF);
    ram_rdata_i = 16'h1357;
    #1;
    check("rst_rdata_follow", cpu_rdata_o, 16'h1357);
    read_chk(16'hF001, 16'h0002, "rst_status");
    cpu_raddr_i = 16'h0100;
    step();
    ram_rdata_i = 16'h2468;
    #1;
    check("ram_read", cpu_rdata_o, 16'h2468);

    // RAM write strobe gating
    cpu_waddr_i = 16'h1234;
    cpu_wdata_i = 16'h00AA;
    cpu_wr_i    = 1'b1;
    #1;
    check("ram_wr_ram", ram_wr_o, 1'b1);
    step();
    cpu_wr_i = 1'b0;
    #1;
    check("ram_wr_idle", ram_wr_o, 1'b0);

    // Single frame of 0x55
    base        = rx_frames;
    cpu_waddr_i = 16'hF000;
    cpu_wdata_i = 16'h0055;
    cpu_wr_i    = 1'b1;
    #1;
    check("ram_wr_io", ram_wr_o, 1'b0);
    step();
    cpu_wr_i = 1'b0;
    check("tx_c1_high", uart_tx_o, 1'b1);
    byte_v = 8'h55;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = byte_v[(k - 4) / 4];
      else             exp_bit = 1'b1;
      check($sformatf("line_c%0d", k + 2), uart_tx_o, exp_bit);
    end
    step();
    read_chk(16'hF001, 16'h0002, "status_after_frame");
    check("frame55_count", rx_frames, base + 1);
    check("frame55_byte", rx_bytes[base % 32], 8'h55);

    // Back-to-back reads: I/O then RAM
    cpu_raddr_i = 16'hF001;
    ram_rdata_i = 16'hDEAD;
    step();
    check("b2b_status", cpu_rdata_o, 16'h0002);
    cpu_raddr_i = 16'h0100;
    step();
    ram_rdata_i = 16'hA5A5;
    #1;
    check("b2b_ram", cpu_rdata_o, 16'hA5A5);

    // Other I/O addresses
    read_chk(16'hF000, 16'h0000, "rd_txdata");
    write(16'hF005, 16'hFFFF);
    read_chk(16'hF005, 16'h0000, "rd_unmapped");
    read_chk(16'hF001, 16'h0002, "status_unmapped_wr");

    // Overflow: 10 pushes, FIFO holds 8 plus one in the shifter
    base = rx_frames;
    for (int i = 0; i < 10; i++) begin
      cpu_waddr_i = 16'hF000;
      cpu_wdata_i = 16'h00A0 + 16'(i);
      cpu_wr_i    = 1'b1;
      step();
    end
    cpu_wr_i = 1'b0;
    read_chk(16'hF001, 16'h0005, "ovf_status");
    write(16'hF001, 16'h0004);
    read_chk(16'hF001, 16'h0001, "ovf_cleared");
    repeat (9 * 40 + 20) step();
    check("ovf_frames", rx_frames, base + 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("ovf_byte%0d", i), rx_bytes[(base + i) % 32], 8'hA0 + 8'(i));
    end
    read_chk(16'hF001, 16'h0002, "ovf_drained");

`ifdef CPU_IO_TIMER_EN
    // Timer load and wrap
    write(16'hF002, 16'hFFFE);
    cpu_raddr_i = 16'hF002;
    step();
    check("timer_c1", cpu_rdata_o, 16'hFFFE);
    step();
    check("timer_c2", cpu_rdata_o, 16'hFFFF);
    step();
    check("timer_c3", cpu_rdata_o, 16'h0000);
`else
    write(16'hF002, 16'h1234);
    read_chk(16'hF002, 16'h0000, "timer_absent");
`endif

    // Reset during DATA
    base = rx_frames;
    write(16'hF000, 16'h000F);
    write(16'hF000, 16'h0033);
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_tx", uart_tx_o, 1'b1);
    read_chk(16'hF001, 16'h0002, "rst_mid_status");
    repeat (100) step();
    check("rst_mid_tx_after", uart_tx_o, 1'b1);
    check("rst_mid_frames", rx_frames, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
